ttl_tri_xcvr_reg: RTL and testbench



---
 rtl/ttl_tri_xcvr_reg.sv | 112 +++++++++++
 tb/tb_ttl_tri_xcvr_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ttl_tri_xcvr_reg.sv
// rtl/ttl_tri_xcvr_reg.sv - registered tridirectional open-collector bus transceiver
// Three W-bit ports joined through one source mux, with a bus-turnaround guard after control changes.
module ttl_tri_xcvr_reg #(
    parameter int W     = 4,
    parameter bit INV_A = 1'b1,
    parameter bit INV_B = 1'b0,
    parameter bit INV_C = 1'b1,
    parameter int TURN  = 1,
    parameter int tPLH  = 21,
    parameter int tPHL  = 9
) (
    input  logic         clk,
    input  logic         rst,
    inout  wire  [W-1:0] a,
    inout  wire  [W-1:0] b,
    inout  wire  [W-1:0] c,
    input  logic         cs,
    input  logic [1:0]   s,
    input  logic         ga,
    input  logic         gb,
    input  logic         gc,
    input  logic         sr,
    input  logic         ce_a,
    input  logic         ce_b,
    input  logic         ce_c,
    output logic         busy
);

    localparam logic [3:0] LP_TURN = 4'(TURN);

    if (TURN < 0 || TURN > 15 || tPLH < 0 || tPHL < 0) begin : g_bad_param
        $error("ttl_tri_xcvr_reg: TURN must be 0..15 and delays non-negative");
    end

    logic [W-1:0] w_na, w_nb, w_nc;
    logic [W-1:0] r_ra, r_rb, r_rc;
    logic [W-1:0] w_src, w_out_a, w_out_b, w_out_c;
    logic [5:0]   w_ctrl, r_ctrl;
    logic [3:0]   r_cnt;
    logic         w_cs_q, w_off, w_drv_a, w_drv_b, w_drv_c;
    logic [1:0]   w_s_q;
    logic [2:0]   w_g_q;

    // Released pins read as 1 through the board pull-ups, so normalising the resolved pin is enough.
    assign w_na = INV_A ? ~a : a;
    assign w_nb = INV_B ? ~b : b;
    assign w_nc = INV_C ? ~c : c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ra <= '1;
            r_rb <= '1;
            r_rc <= '1;
        end else begin
            if (ce_a) r_ra <= w_na;
            if (ce_b) r_rb <= w_nb;
            if (ce_c) r_rc <= w_nc;
        end
    end

    assign w_ctrl = {cs, s, ga, gb, gc};
    assign w_cs_q = r_ctrl[5];
    assign w_s_q  = r_ctrl[4:3];
    assign w_g_q  = r_ctrl[2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl <= 6'b1_11_111;
            r_cnt  <= 4'd0;
        end else if (w_ctrl != r_ctrl) begin
            r_ctrl <= w_ctrl;
            r_cnt  <= LP_TURN;
        end else if (r_cnt != 4'd0) begin
            r_cnt  <= r_cnt - 4'd1;
        end
    end

    assign busy = (r_cnt != 4'd0);

    always_comb begin
        w_src = '1;
        case (w_s_q)
            2'b00:   w_src = sr ? r_ra : w_na;
            2'b01:   w_src = sr ? r_rb : w_nb;
            2'b10:   w_src = sr ? r_rc : w_nc;
            default: w_src = '1;
        endcase
    end

    // A transfer with no enabled destination is treated the same as fully off.
    assign w_off = w_cs_q
                 | (w_s_q == 2'b11)
                 | (&w_g_q)
                 | ((w_s_q == 2'b00) & w_g_q[1] & w_g_q[0])
                 | ((w_s_q == 2'b01) & w_g_q[2] & w_g_q[0])
                 | ((w_s_q == 2'b10) & w_g_q[2] & w_g_q[1]);

    assign w_drv_a = !w_off && (r_cnt == 4'd0) && !w_g_q[2] && (w_s_q != 2'b00);
    assign w_drv_b = !w_off && (r_cnt == 4'd0) && !w_g_q[1] && (w_s_q != 2'b01);
    assign w_drv_c = !w_off && (r_cnt == 4'd0) && !w_g_q[0] && (w_s_q != 2'b10);

    assign w_out_a = INV_A ? ~w_src : w_src;
    assign w_out_b = INV_B ? ~w_src : w_src;
    assign w_out_c = INV_C ? ~w_src : w_src;

    for (genvar i = 0; i < W; i++) begin : g_pins
        assign a[i] = (w_drv_a && !w_out_a[i]) ? 1'b0 : 1'bz;
        assign b[i] = (w_drv_b && !w_out_b[i]) ? 1'b0 : 1'bz;
        assign c[i] = (w_drv_c && !w_out_c[i]) ? 1'b0 : 1'bz;
    end

endmodule

// File: tb/tb_ttl_tri_xcvr_reg.sv
// tb/tb_ttl_tri_xcvr_reg.sv - self-checking bench for ttl_tri_xcvr_reg
// Directed scenarios followed by randomized traffic against a wired-AND bus reference model.
module tb_ttl_tri_xcvr_reg;

    localparam int W     = 4;
    localparam bit INV_A = 1'b1;
    localparam bit INV_B = 1'b0;
    localparam bit INV_C = 1'b1;
    localparam int TP    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cs = 1'b1, ga = 1'b1, gb = 1'b1, gc = 1'b1, sr = 1'b0;
    logic ce_a = 1'b0, ce_b = 1'b0, ce_c = 1'b0;
    logic [1:0] s = 2'b11;
    logic busy;
    wire  [W-1:0] a, b, c;

    logic         tb_a_oe = 1'b0, tb_b_oe = 1'b0, tb_c_oe = 1'b0;
    logic [W-1:0] tb_a = '1, tb_b = '1, tb_c = '1;

    int n_tests = 0;
    int n_fail  = 0;

    logic         m_cs;
    logic [1:0]   m_s;
    logic [2:0]   m_g;
    int           m_cnt;
    logic [W-1:0] m_ra, m_rb, m_rc;
    logic [W-1:0] e_a, e_b, e_c;

    always #5 clk = ~clk;

    for (genvar i = 0; i < W; i++) begin : g_bus
        pullup (a[i]);
        pullup (b[i]);
        pullup (c[i]);
        assign a[i] = (tb_a_oe && !tb_a[i]) ? 1'b0 : 1'bz;
        assign b[i] = (tb_b_oe && !tb_b[i]) ? 1'b0 : 1'bz;
        assign c[i] = (tb_c_oe && !tb_c[i]) ? 1'b0 : 1'bz;
    end

    ttl_tri_xcvr_reg #(
        .W(W), .INV_A(INV_A), .INV_B(INV_B), .INV_C(INV_C),
        .TURN(TP), .tPLH(21), .tPHL(9)
    ) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .cs(cs), .s(s), .ga(ga), .gb(gb), .gc(gc), .sr(sr),
        .ce_a(ce_a), .ce_b(ce_b), .ce_c(ce_c), .busy(busy)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_cs = 1'b1; m_s = 2'b11; m_g = 3'b111; m_cnt = 0;
        m_ra = '1; m_rb = '1; m_rc = '1;
    endfunction

    // Bus levels follow from who pulls each line low; released lines float to 1.
    function automatic void model_eval();
        logic [W-1:0] pt[3];
        logic [W-1:0] rg[3];
        logic [W-1:0] pin[3];
        logic         inv[3];
        logic         gx[3];
        logic         off, nsrc_dis;
        logic [W-1:0] src, outv;
        pt[0] = tb_a_oe ? tb_a : '1;
        pt[1] = tb_b_oe ? tb_b : '1;
        pt[2] = tb_c_oe ? tb_c : '1;
        rg[0] = m_ra; rg[1] = m_rb; rg[2] = m_rc;
        inv[0] = INV_A; inv[1] = INV_B; inv[2] = INV_C;
        gx[0] = m_g[2]; gx[1] = m_g[1]; gx[2] = m_g[0];
        nsrc_dis = 1'b1;
        for (int x = 0; x < 3; x++)
            if (x != int'(m_s) && !gx[x]) nsrc_dis = 1'b0;
        off = m_cs || (m_s == 2'b11) || (m_g == 3'b111) || nsrc_dis;
        src = '1;
        if (m_s != 2'b11)
            src = sr ? rg[m_s] : (inv[m_s] ? ~pt[m_s] : pt[m_s]);
        for (int x = 0; x < 3; x++) begin
            outv   = inv[x] ? ~src : src;
            pin[x] = pt[x];
            if (!off && m_cnt == 0 && !gx[x] && x != int'(m_s))
                pin[x] = pt[x] & outv;
        end
        e_a = pin[0]; e_b = pin[1]; e_c = pin[2];
    endfunction

    function automatic void model_clock();
        if (ce_a) m_ra = INV_A ? ~e_a : e_a;
        if (ce_b) m_rb = INV_B ? ~e_b : e_b;
        if (ce_c) m_rc = INV_C ? ~e_c : e_c;
        if ({cs, s, ga, gb, gc} != {m_cs, m_s, m_g}) begin
            {m_cs, m_s, m_g} = {cs, s, ga, gb, gc};
            m_cnt = TP;
        end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
        end
    endfunction

    task automatic check_all(input string tag);
        model_eval();
        chk({tag, ".a"}, a, e_a);
        chk({tag, ".b"}, b, e_b);
        chk({tag, ".c"}, c, e_c);
        chk({tag, ".busy"}, W'(busy), W'(m_cnt != 0));
    endtask

    task automatic step(input string tag);
        #1;
        if (rst) model_reset();
        check_all(tag);
        if (!rst) model_clock();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ctrl(input logic i_cs, input logic [1:0] i_s, input logic i_ga,
                            input logic i_gb, input logic i_gc);
        cs = i_cs; s = i_s; ga = i_ga; gb = i_gb; gc = i_gc;
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // Reset: everything released, guard idle.
        step("reset");
        chk("reset_a", a, 4'b1111);
        chk("reset_busy", W'(busy), '0);

        // Live A->B.
        rst = 1'b0;
        set_ctrl(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        sr = 1'b0; tb_a_oe = 1'b1; tb_a = 4'b1010;
        repeat (4) step("live_ab");
        #1 chk("live_ab_b", b, 4'b0101);

        // Registered mode: captured A keeps feeding B.
        ce_a = 1'b1; tb_a = 4'b0011;
        step("cap_a");
        ce_a = 1'b0; tb_a = 4'b1111; sr = 1'b1;
        step("reg_mode");
        #1 chk("reg_mode_b", b, 4'b1100);

        // Turnaround to B as source.
        set_ctrl(1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
        sr = 1'b0; tb_a_oe = 1'b0; tb_b_oe = 1'b1; tb_b = 4'b0110;
        repeat (4) step("turn");
        #1 chk("turn_a", a, 4'b1001);
        chk("turn_c", c, 4'b1001);

        // Asynchronous reset mid-transfer.
        #2 rst = 1'b1;
        #1 chk("async_rst_a", a, 4'b1111);
        chk("async_rst_c", c, 4'b1111);
        chk("async_rst_busy", W'(busy), '0);
        @(negedge clk);
        step("in_reset");
        rst = 1'b0; tb_b_oe = 1'b0;
        set_ctrl(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        sr = 1'b1;
        repeat (4) step("post_rst");
        #1 chk("post_rst_ra_b", b, 4'b1111);

        // Off conditions.
        tb_a_oe = 1'b1; tb_a = 4'b0000; sr = 1'b0;
        set_ctrl(1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
        repeat (4) step("off_s11");
        #1 chk("off_s11_b", b, 4'b1111);
        chk("off_s11_busy", W'(busy), '0);
        set_ctrl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        repeat (4) step("off_cs");
        #1 chk("off_cs_b", b, 4'b1111);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) == 0) begin
                set_ctrl($urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)),
                         1'($urandom), 1'($urandom), 1'($urandom));
            end
            sr   = 1'($urandom);
            ce_a = 1'($urandom); ce_b = 1'($urandom); ce_c = 1'($urandom);
            tb_a_oe = ($urandom_range(0, 2) == 0); tb_a = W'($urandom);
            tb_b_oe = ($urandom_range(0, 2) == 0); tb_b = W'($urandom);
            tb_c_oe = ($urandom_range(0, 2) == 0); tb_c = W'($urandom);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
